// File: rtl/rpn_pkg.sv
// Shared constants, state encoding and byte classification for the RPN front end.
// The tokenizer and its decimal accumulator both import this package.
package rpn_pkg;

  localparam int TOK_DW = 32;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;

  localparam logic FLAG_NUM = 1'b1;
  localparam logic FLAG_OP  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NUM,
    ST_OUT_NUM,
    ST_OUT_OP
  } state_t;

  typedef enum logic [1:0] {
    CLS_DIGIT,
    CLS_SEP,
    CLS_OP,
    CLS_BAD
  } byte_cls_t;

  function automatic byte_cls_t classify(input logic [7:0] b);
    byte_cls_t cls;
    if (b >= ASCII_0 && b <= ASCII_9)
      cls = CLS_DIGIT;
    else if (b == ASCII_SP || b == ASCII_CR || b == ASCII_LF)
      cls = CLS_SEP;
    else if (b == ASCII_PLUS || b == ASCII_MINUS || b == ASCII_STAR)
      cls = CLS_OP;
    else
      cls = CLS_BAD;
    return cls;
  endfunction

endpackage

// File: rtl/dec_acc.sv
// Combinational decimal step: acc_out = acc_in*10 + digit, saturating to all-ones.
// ovf flags that the true result did not fit in DW bits.
module dec_acc
  import rpn_pkg::*;
#(
  parameter int DW = TOK_DW
) (
  input  logic [DW-1:0] acc_in,
  input  logic [3:0]    digit,
  output logic [DW-1:0] acc_out,
  output logic          ovf
);

  // Four guard bits hold (2^DW-1)*10+9 without wrapping.
  logic [DW+3:0] wide;

  always_comb begin
    wide    = ({4'd0, acc_in} << 3) + ({4'd0, acc_in} << 1) + {{DW{1'b0}}, digit};
    ovf     = |wide[DW+3:DW];
    acc_out = ovf ? {DW{1'b1}} : wide[DW-1:0];
  end

endmodule

// File: rtl/rpn_tokenizer.sv
// ASCII byte stream to RPN token stream: unsigned decimal numbers and + - * operators,
// with valid/ack handshakes on both sides and a sticky error flag.
module rpn_tokenizer
  import rpn_pkg::*;
#(
  parameter int DW         = TOK_DW,
  parameter int MAX_DIGITS = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    I_DAT,
  input  logic          I_STB,
  output logic          I_ACK,
  output logic [DW-1:0] O_DAT,
  output logic          O_NUM_OR_OP,
  output logic          O_STB,
  input  logic          O_ACK,
  output logic          ERR
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 2);

  state_t          state;
  logic [DW-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic [7:0]      pend_op;

  logic [DW-1:0]   acc_next;
  logic            acc_ovf;
  logic [3:0]      digit;
  logic            cnt_full;
  byte_cls_t       cls;

  // Digits are 0x30..0x39, so the low nibble is the value.
  assign digit    = I_DAT[3:0];
  assign cls      = classify(I_DAT);
  assign cnt_full = (cnt >= CNT_W'(MAX_DIGITS));
  assign I_ACK    = (state == ST_IDLE) || (state == ST_NUM);

  dec_acc #(
    .DW(DW)
  ) u_dec_acc (
    .acc_in (acc),
    .digit  (digit),
    .acc_out(acc_next),
    .ovf    (acc_ovf)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cnt         <= '0;
      pend_op     <= '0;
      O_DAT       <= '0;
      O_NUM_OR_OP <= 1'b0;
      O_STB       <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_NUM: begin
          if (I_STB) begin
            case (cls)
              CLS_DIGIT: begin
                state <= ST_NUM;
                // Saturate but keep consuming digits so the number still terminates normally.
                if (acc_ovf || cnt_full) begin
                  acc <= {DW{1'b1}};
                  ERR <= 1'b1;
                end else begin
                  acc <= acc_next;
                end
                if (!cnt_full)
                  cnt <= cnt + CNT_W'(1);
              end
              CLS_SEP, CLS_OP: begin
                if (state == ST_NUM) begin
                  state       <= ST_OUT_NUM;
                  O_DAT       <= acc;
                  O_NUM_OR_OP <= FLAG_NUM;
                  O_STB       <= 1'b1;
                  acc         <= '0;
                  cnt         <= '0;
                  if (cls == CLS_OP)
                    pend_op <= I_DAT;
                end else if (cls == CLS_OP) begin
                  state       <= ST_OUT_OP;
                  O_DAT       <= {{(DW-8){1'b0}}, I_DAT};
                  O_NUM_OR_OP <= FLAG_OP;
                  O_STB       <= 1'b1;
                end
              end
              default: begin
                ERR   <= 1'b1;
                acc   <= '0;
                cnt   <= '0;
                state <= ST_IDLE;
              end
            endcase
          end
        end
        ST_OUT_NUM: begin
          if (O_STB && O_ACK) begin
            // A trailing operator goes out immediately after the number, no bubble.
            if (pend_op != 8'd0) begin
              state       <= ST_OUT_OP;
              O_DAT       <= {{(DW-8){1'b0}}, pend_op};
              O_NUM_OR_OP <= FLAG_OP;
              pend_op     <= '0;
            end else begin
              state <= ST_IDLE;
              O_STB <= 1'b0;
            end
          end
        end
        ST_OUT_OP: begin
          if (O_STB && O_ACK) begin
            state <= ST_IDLE;
            O_STB <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
